// File: rtl/link_pkg.sv
// Shared definitions for the serial router link: payload width, framing bits
// and the receive FSM state encoding used by transmitter and receiver.
package link_pkg;

    localparam int LINK_WIDTH = 55;
    localparam int CNT_W      = 6;

    localparam logic IDLE_BIT  = 1'b0;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2,
        FLUSH = 2'd3
    } rx_state_t;

endpackage

// File: rtl/receiver_if.sv
// Parallel side of the receive stage: payload word, valid/ready handshake and
// the two error pulses.
interface receiver_if #(
    parameter int WIDTH = link_pkg::LINK_WIDTH
);
    // A word moves on every rising clock edge where RX_Data_Valid && RX_Ready.
    // The producer holds RX_Data stable while valid and not yet accepted;
    // valid never depends combinationally on ready.
    logic [WIDTH-1:0] RX_Data;
    logic             RX_Data_Valid;
    logic             RX_Ready;
    logic             RX_Overrun;
    logic             RX_Frame_Err;

    modport master (
        output RX_Data,
        output RX_Data_Valid,
        output RX_Overrun,
        output RX_Frame_Err,
        input  RX_Ready
    );

    modport slave (
        input  RX_Data,
        input  RX_Data_Valid,
        input  RX_Overrun,
        input  RX_Frame_Err,
        output RX_Ready
    );
endinterface

// File: rtl/rx_hold_buf.sv
// Single-entry valid/ready holding register. A load that arrives while full
// and not draining is dropped and reported as a one-cycle overrun pulse.
module rx_hold_buf #(
    parameter int WIDTH = link_pkg::LINK_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            // A slot freed by this cycle's transfer can be refilled at once.
            if (load) begin
                if (!valid || ready) begin
                    data  <= load_data;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/receiver.sv
// Serial-to-parallel receive stage: deframes start/payload/stop on S_Data and
// hands each good word to the holding register.
module receiver
    import link_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
) (
    input  logic      Clk_S,
    input  logic      Rst,
    input  logic      S_Data,
    receiver_if.master rx,
    output rx_state_t dbg_state
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_t        state;
    rx_state_t        next_state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] shreg;
    logic             start_det;
    logic             shift_en;
    logic             good_d;
    logic             err_d;
    logic             frame_good;
    logic             frame_err_q;
    logic             frame_err_out;

    assign dbg_state = state;

    always_ff @(posedge Clk_S or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        good_d     = 1'b0;
        err_d      = 1'b0;
        case (state)
            IDLE: begin
                if (S_Data == START_BIT) begin
                    start_det  = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (count == LAST_BIT) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (S_Data == STOP_BIT) begin
                    good_d     = 1'b1;
                    next_state = IDLE;
                end else begin
                    err_d      = 1'b1;
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                // A line stuck high must fall before a new start bit counts.
                if (S_Data == IDLE_BIT) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk_S or posedge Rst) begin
        if (Rst) begin
            count         <= '0;
            shreg         <= '0;
            frame_good    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            if (start_det) begin
                count <= '0;
                shreg <= '0;
            end else if (shift_en) begin
                shreg[count] <= S_Data;
                if (count != LAST_BIT) begin
                    count <= count + 1'b1;
                end
            end
            frame_good    <= good_d;
            frame_err_q   <= err_d;
            frame_err_out <= frame_err_q;
        end
    end

    // shreg still holds the finished word on the load edge even if a new start
    // bit clears it at that same edge.
    rx_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk       (Clk_S),
        .rst       (Rst),
        .load      (frame_good),
        .load_data (shreg),
        .ready     (rx.RX_Ready),
        .data      (rx.RX_Data),
        .valid     (rx.RX_Data_Valid),
        .overrun   (rx.RX_Overrun)
    );

    assign rx.RX_Frame_Err = frame_err_out;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: framing, latency, back-pressure, overrun,
// framing error, async reset and a short back-to-back burst.
module tb_receiver;
    import link_pkg::*;

    localparam int W = LINK_WIDTH;

    logic      clk;
    logic      rst;
    logic      s_data;
    rx_state_t dbg_state;

    receiver_if #(.WIDTH(W)) rx ();

    receiver #(.WIDTH(W)) dut (
        .Clk_S     (clk),
        .Rst       (rst),
        .S_Data    (s_data),
        .rx        (rx),
        .dbg_state (dbg_state)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ovr_cnt  = 0;
    int err_cnt  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic stop);
        logic [W+1:0] f;
        f = {stop, word, START_BIT};
        for (int i = 0; i < W + 2; i++) begin
            tick();
            s_data = f[i];
        end
    endtask

    // scoreboard: every transfer must match the head of the expected queue
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            if (rx.RX_Data_Valid && rx.RX_Ready) begin
                if (exp_q.size() == 0) begin
                    check("xfer_unexpected_q_size", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_data", 64'(rx.RX_Data), 64'(e));
                end
            end
            if (rx.RX_Overrun) ovr_cnt++;
            if (rx.RX_Frame_Err) err_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        rst         = 1'b1;
        s_data      = 1'b0;
        rx.RX_Ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 64'(rx.RX_Data_Valid), 64'd0);
        check("rst_data", 64'(rx.RX_Data), 64'd0);
        check("rst_ovr", 64'(rx.RX_Overrun), 64'd0);
        check("rst_err", 64'(rx.RX_Frame_Err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b0;
        repeat (2) tick();

        // single frame, 57-cycle latency, valid for exactly one cycle
        rx.RX_Ready = 1'b1;
        exp_q.push_back(55'h12_3456_789A_BCDE);
        send_frame(55'h12_3456_789A_BCDE, STOP_BIT);
        tick(); s_data = 1'b0;
        check("single_valid_t56", 64'(rx.RX_Data_Valid), 64'd0);
        tick();
        check("single_valid_t57", 64'(rx.RX_Data_Valid), 64'd1);
        check("single_data_t57", 64'(rx.RX_Data), 64'h12_3456_789A_BCDE);
        tick();
        check("single_valid_t58", 64'(rx.RX_Data_Valid), 64'd0);

        // held word plus partial frame, then asynchronous reset between edges
        rx.RX_Ready = 1'b0;
        send_frame(55'h5, STOP_BIT);
        tick(); s_data = 1'b0;
        tick();
        check("hold_valid", 64'(rx.RX_Data_Valid), 64'd1);
        check("hold_data", 64'(rx.RX_Data), 64'h5);
        for (int i = 0; i < 11; i++) begin
            tick(); s_data = 1'b1;
        end
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(rx.RX_Data_Valid), 64'd0);
        check("async_rst_data", 64'(rx.RX_Data), 64'd0);
        check("async_rst_state", 64'(dbg_state), 64'(IDLE));
        tick(); s_data = 1'b0; rst = 1'b0;
        repeat (2) tick();
        rx.RX_Ready = 1'b1;
        exp_q.push_back(55'h3);
        send_frame(55'h3, STOP_BIT);
        repeat (3) begin tick(); s_data = 1'b0; end

        // back-pressure: second frame overruns, first is kept
        rx.RX_Ready = 1'b0;
        exp_q.push_back(55'h1);
        send_frame(55'h1, STOP_BIT);
        send_frame(55'h7F_FFFF_FFFF_FFFF, STOP_BIT);
        tick(); s_data = 1'b0;
        check("bp_data_t56", 64'(rx.RX_Data), 64'h1);
        check("bp_ovr_t56", 64'(rx.RX_Overrun), 64'd0);
        tick();
        check("bp_ovr_t57", 64'(rx.RX_Overrun), 64'd1);
        check("bp_data_t57", 64'(rx.RX_Data), 64'h1);
        check("bp_valid_t57", 64'(rx.RX_Data_Valid), 64'd1);
        tick();
        check("bp_ovr_t58", 64'(rx.RX_Overrun), 64'd0);
        rx.RX_Ready = 1'b1;
        tick();
        check("bp_drained", 64'(rx.RX_Data_Valid), 64'd0);
        rx.RX_Ready = 1'b0;

        // accept and reload on the same edge
        exp_q.push_back(55'h0A_BCDE_F012_3456);
        exp_q.push_back(55'h55_5555_5555_5555);
        send_frame(55'h0A_BCDE_F012_3456, STOP_BIT);
        send_frame(55'h55_5555_5555_5555, STOP_BIT);
        tick(); s_data = 1'b0;
        check("same_data_t56", 64'(rx.RX_Data), 64'h0A_BCDE_F012_3456);
        rx.RX_Ready = 1'b1;
        tick();
        check("same_valid_t57", 64'(rx.RX_Data_Valid), 64'd1);
        check("same_data_t57", 64'(rx.RX_Data), 64'h55_5555_5555_5555);
        check("same_ovr_t57", 64'(rx.RX_Overrun), 64'd0);
        tick();
        check("same_valid_t58", 64'(rx.RX_Data_Valid), 64'd0);

        // framing error with the line stuck high, then a good frame
        exp_q.push_back(55'h2A);
        send_frame(55'h15_0F0F_0F0F_0F0F, 1'b1);
        tick(); s_data = 1'b1;
        check("ferr_t56", 64'(rx.RX_Frame_Err), 64'd0);
        tick(); s_data = 1'b1;
        check("ferr_t57", 64'(rx.RX_Frame_Err), 64'd1);
        check("ferr_no_valid", 64'(rx.RX_Data_Valid), 64'd0);
        tick(); s_data = 1'b1;
        check("ferr_t58", 64'(rx.RX_Frame_Err), 64'd0);
        check("ferr_flush_state", 64'(dbg_state), 64'(FLUSH));
        tick(); s_data = 1'b0;
        send_frame(55'h2A, STOP_BIT);
        repeat (3) begin tick(); s_data = 1'b0; end

        // back-to-back burst with random payloads
        for (int k = 0; k < 8; k++) begin
            w = W'({$urandom(), $urandom()});
            exp_q.push_back(w);
            send_frame(w, STOP_BIT);
        end
        repeat (4) begin tick(); s_data = 1'b0; end

        check("end_q_empty", 64'(exp_q.size()), 64'd0);
        check("end_ovr_count", 64'(ovr_cnt), 64'd1);
        check("end_err_count", 64'(err_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
